// File: rtl/instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage
//
// MIPS instruction fetch stage together with the IF/ID pipeline register.
// Holds the fetch PC, drives the instruction memory address straight from it,
// and latches the fetched word and its PC+4 into IF/ID for decode. Handles
// redirects from taken branches (EX), jumps and JR (ID). It also handles
// hazard stalls and inserts bubbles on redirects and instruction-memory misses.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous reset, active-high
//   stall          hazard unit request: hold PC and IF/ID
//   branch_taken   taken branch resolved in EX
//   branch_target  branch destination from EX
//   jump           the instruction in IF/ID is J or JAL
//   jr             the instruction in IF/ID is JR
//   jr_target      rs value for JR
//   imem_addr      instruction memory byte address (equals pc)
//   imem_rdata     instruction word at imem_addr
//   imem_ready     imem_rdata is valid this cycle
//   pc             current fetch PC
//   ifid_instr     instruction handed to decode
//   ifid_pc4       PC+4 of ifid_instr (branch base / JAL link)
//   ifid_valid     ifid_instr is a real instruction (0 = bubble)
// ---------------------------------------------------------------------------
module instruction_fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic                  jr,
  input  logic [DATA_WIDTH-1:0] jr_target,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  imem_ready,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] ifid_instr,
  output logic [DATA_WIDTH-1:0] ifid_pc4,
  output logic                  ifid_valid
);

  // Clears the two byte-offset bits so every fetch address is word aligned.
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [DATA_WIDTH-1:0] ifid_pc4_q, ifid_pc4_d;
  logic                  ifid_valid_q, ifid_valid_d;

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] jump_target;

  // Sequential increment wraps naturally at the top of the address space.
  assign pc_plus4 = pc_q + DATA_WIDTH'(4);

  // J/JAL keep the upper nibble of the delay-slot PC and take the 26-bit
  // word index from the instruction itself.
  assign jump_target = {ifid_pc4_q[DATA_WIDTH-1:DATA_WIDTH-4], ifid_instr_q[25:0], 2'b00};

  // Next-state selection. The if/else order is the priority order: a taken
  // branch beats a stall because the instruction causing the stall is on the
  // wrong path anyway. A stall beats jump/jr so the jump is seen again once
  // the stall releases. jump/jr only act when IF/ID holds a real instruction.
  // Every redirect and every miss drops a bubble into IF/ID. ifid_pc4 keeps
  // its last value across bubbles.
  always_comb begin
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;

    if (branch_taken) begin
      pc_d         = branch_target & ALIGN_MASK;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (jr && ifid_valid_q) begin
      pc_d         = jr_target & ALIGN_MASK;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (jump && ifid_valid_q) begin
      pc_d         = jump_target;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (imem_ready) begin
      pc_d         = pc_plus4;
      ifid_instr_d = imem_rdata;
      ifid_pc4_d   = pc_plus4;
      ifid_valid_d = 1'b1;
    end else begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end
  end

  // PC and IF/ID registers. Reset may arrive at any point, including in the
  // middle of a redirect or a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign ifid_valid = ifid_valid_q;

endmodule
